sum_accum_pipe: RTL and testbench
=================================

# sum_accum_pipe

Parametrised, pipelined two-operand adder/accumulator for the TinyTapeout user tile. It replaces a purely combinational byte adder with a valid/ready streaming unit. Each accepted operand pair is summed, then applied to a running accumulator according to an opcode, with optional saturation and a sticky overflow flag. It sits between the tile's input-pin deserialiser and the output-pin driver.

## Interface

Parameters:
- WIDTH, 8: operand width in bits (≥2).
- ACC_WIDTH, 12: accumulator/result width (≥ WIDTH+1).
- SATURATE, 1: 1 = clamp to [0, 2^ACC_WIDTH−1]; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_op  in  2  opcode: 00 LOAD, 01 ACC, 10 SUB, 11 CLR.
- in_valid  in  1  operand/opcode present.
- in_ready  out  1  unit can accept this cycle.
- out_sum  out  ACC_WIDTH  accumulator value after the op.
- out_valid  out  1  out_sum valid.
- out_ready  in  1  downstream accepts out_sum.
- overflow  out  1  sticky saturation/wrap indicator.

## Operation

- Transfer at input when in_valid & in_ready; at output when out_valid & out_ready.
- Stage 1 (S1): registers s = in_a + in_b (WIDTH+1 bits, no loss) and in_op; flag s1_valid.
- Stage 2 (S2): on S1→S2 move, computes the new accumulator value, registers it into acc (drives out_sum), and sets out_valid.
  - LOAD: acc := zero-extended s.
  - ACC: acc := acc + s, computed in ACC_WIDTH+1 bits.
  - SUB: acc := acc − s, computed in ACC_WIDTH+1 bits with borrow.
  - CLR: acc := 0; overflow := 0; a result (0) is still emitted.
- Range handling: on carry-out (ACC) or borrow (SUB):
  - SATURATE=1: clamp to 2^ACC_WIDTH−1 (carry) or 0 (borrow).
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - In both modes overflow := 1. It stays set until CLR or rst.
- Flow control:
  - s2_free = ~out_valid | out_ready.
  - S1→S2 move occurs when s1_valid & s2_free.
  - in_ready = ~s1_valid | s2_free. This is combinational from out_ready; no dependence on in_valid.
- out_valid clears on an output transfer if no S1→S2 move happens that cycle.
- out_sum and overflow hold stable while out_valid & ~out_ready.
- Ops apply strictly in acceptance order. acc is never modified except by an S1→S2 move.

## Timing

- Reset values: in_ready 1, out_valid 0, out_sum 0, overflow 0, s1_valid 0, acc 0.
- rst asserted mid-stream discards S1 and S2 contents on that edge. Inputs presented during rst are not accepted.
- Latency: a pair accepted at edge N has its result on out_sum with out_valid=1 after edge N+1 (two registers), provided there is no backpressure.
- Throughput: one op per cycle with out_ready held high.
- Under backpressure, at most 2 ops are buffered (S1 + S2). in_ready drops on the cycle S1 is full and S2 is stalled.
- Simultaneous output transfer and S1→S2 move in one cycle: out_valid stays 1 and out_sum updates to the new value.
- overflow updates on the same edge as the out_sum it describes.

## Test plan

- **Reset/LOAD:** rst for 2 cycles, then LOAD a=200, b=100, out_ready=1.
  - Required: out_sum=300, out_valid=1 exactly 2 edges after acceptance, overflow=0.
- **ACC saturate (SATURATE=1):** CLR, then 9× ACC a=255, b=255 back-to-back.
  - Required: results 510, 1020, …, 4080, then 4095 with overflow=1.
  - A following CLR yields 0 with overflow=0.
- **ACC wrap (SATURATE=0):** same stimulus as the saturate case.
  - Required: 9th result is 494, overflow=1.
- **SUB underflow:** LOAD 200+100, then SUB 255+255.
  - SATURATE=1: 0. SATURATE=0: 3886. overflow=1 in both.
- **Backpressure:** out_ready=0 for 4 cycles while in_valid=1 with LOAD values 1, 2, 3, 4.
  - Required: exactly 2 accepted, in_ready=0 afterwards, out_sum held at first result.
  - On release: remaining results emitted in order with no loss or duplication.
- **Reset mid-stream:** assert rst with S1 and S2 both full.
  - Required: next cycle out_valid=0, out_sum=0, in_ready=1.
  - A subsequent ACC 5+5 yields 10.

Source files
------------

// File: rtl/sum_accum_pipe_if.sv
// Streaming bus for sum_accum_pipe: operand/opcode request side and result side.
interface sum_accum_pipe_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12
);
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [1:0]           in_op;
  logic                 in_valid;
  logic                 in_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;

  modport master (
    output in_a, in_b, in_op, in_valid, out_ready,
    input  in_ready, out_sum, out_valid, overflow
  );

  modport slave (
    input  in_a, in_b, in_op, in_valid, out_ready,
    output in_ready, out_sum, out_valid, overflow
  );
endinterface

// File: rtl/sum_accum_pipe.sv
// Two-stage valid/ready adder/accumulator: S1 registers a+b, S2 applies the
// opcode to the running accumulator with optional saturation and sticky overflow.
module sum_accum_pipe #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 12,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  sum_accum_pipe_if.slave     io
);
  localparam int STAGES = 2;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ACC  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef struct packed {
    logic [WIDTH:0] s;
    op_e            op;
  } s1_t;

  logic [STAGES:1]    vld_pipe;
  s1_t                s1;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic               ovf, ovf_nxt;
  logic               s2_free, move, in_fire;
  logic [ACC_WIDTH:0] s_ext, sum_ext, diff_ext;

  assign s2_free     = ~vld_pipe[2] | io.out_ready;
  assign move        = vld_pipe[1] & s2_free;
  assign io.in_ready = ~vld_pipe[1] | s2_free;
  assign in_fire     = io.in_valid & io.in_ready;

  assign io.out_valid = vld_pipe[2];
  assign io.out_sum   = acc;
  assign io.overflow  = ovf;

  // One extra bit exposes the carry (ACC) or the borrow (SUB) as the MSB.
  assign s_ext    = {{(ACC_WIDTH-WIDTH){1'b0}}, s1.s};
  assign sum_ext  = {1'b0, acc} + s_ext;
  assign diff_ext = {1'b0, acc} - s_ext;

  always_comb begin
    acc_nxt = acc;
    ovf_nxt = ovf;
    case (s1.op)
      OP_LOAD: acc_nxt = s_ext[ACC_WIDTH-1:0];
      OP_ACC: begin
        if (sum_ext[ACC_WIDTH]) begin
          acc_nxt = SATURATE ? '1 : sum_ext[ACC_WIDTH-1:0];
          ovf_nxt = 1'b1;
        end else begin
          acc_nxt = sum_ext[ACC_WIDTH-1:0];
        end
      end
      OP_SUB: begin
        if (diff_ext[ACC_WIDTH]) begin
          acc_nxt = SATURATE ? '0 : diff_ext[ACC_WIDTH-1:0];
          ovf_nxt = 1'b1;
        end else begin
          acc_nxt = diff_ext[ACC_WIDTH-1:0];
        end
      end
      OP_CLR: begin
        acc_nxt = '0;
        ovf_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      if (in_fire) begin
        s1.s  <= {1'b0, io.in_a} + {1'b0, io.in_b};
        s1.op <= op_e'(io.in_op);
      end
      // in_ready implies S1 is either empty or draining this cycle
      if (io.in_ready) vld_pipe[1] <= io.in_valid;
      if (move) begin
        acc         <= acc_nxt;
        ovf         <= ovf_nxt;
        vld_pipe[2] <= 1'b1;
      end else if (io.out_ready) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sum_accum_pipe.sv
// Bench: saturating and wrapping instances driven in lockstep, checked every
// cycle against an arithmetic reference model plus directed literal results.
module tb_sum_accum_pipe;
  localparam int W  = 8;
  localparam int AW = 12;
  localparam int MAXV = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [1:0]   in_op = 2'b00;
  logic         in_valid = 1'b0, out_ready = 1'b1;

  always #5 clk = ~clk;

  sum_accum_pipe_if #(.WIDTH(W), .ACC_WIDTH(AW)) bs ();
  sum_accum_pipe_if #(.WIDTH(W), .ACC_WIDTH(AW)) bw ();

  assign bs.in_a = in_a;  assign bw.in_a = in_a;
  assign bs.in_b = in_b;  assign bw.in_b = in_b;
  assign bs.in_op = in_op; assign bw.in_op = in_op;
  assign bs.in_valid = in_valid; assign bw.in_valid = in_valid;
  assign bs.out_ready = out_ready; assign bw.out_ready = out_ready;

  sum_accum_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .io(bs));
  sum_accum_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .io(bw));

  typedef struct {
    int sat; bit osat; int wrp; bit owrp; int edge_no;
  } item_t;

  item_t q[$];
  item_t log_q[$];
  int  checks = 0, errors = 0, cyc = 0;
  int  m_sat = 0, m_wrp = 0;
  bit  o_sat = 0, o_wrp = 0, started = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Plain-integer reference of one op applied to an accumulator value.
  task automatic apply(input int op, input int s, input bit sat,
                       inout int m, inout bit o);
    int t;
    case (op)
      0: m = s;
      1: begin
        t = m + s;
        if (t > MAXV) begin o = 1; m = sat ? MAXV : (t % (MAXV + 1)); end
        else m = t;
      end
      2: begin
        if (s > m) begin o = 1; m = sat ? 0 : (m - s + MAXV + 1); end
        else m = m - s;
      end
      default: begin m = 0; o = 0; end
    endcase
  endtask

  always @(posedge clk) cyc++;

  // Compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    int n;
    bit exp_iv, exp_ov;
    item_t it;
    n = q.size();
    exp_iv = (n < 2) || out_ready;
    exp_ov = (n >= 2) || (n == 1 && q[0].edge_no < cyc);
    if (started) begin
      chk("in_ready_sat", int'(bs.in_ready), int'(exp_iv));
      chk("in_ready_wrap", int'(bw.in_ready), int'(exp_iv));
      chk("out_valid_sat", int'(bs.out_valid), int'(exp_ov));
      chk("out_valid_wrap", int'(bw.out_valid), int'(exp_ov));
      if (exp_ov) begin
        chk("out_sum_sat", int'(bs.out_sum), q[0].sat);
        chk("overflow_sat", int'(bs.overflow), int'(q[0].osat));
        chk("out_sum_wrap", int'(bw.out_sum), q[0].wrp);
        chk("overflow_wrap", int'(bw.overflow), int'(q[0].owrp));
      end else if (n == 0) begin
        chk("idle_sum_sat", int'(bs.out_sum), m_sat);
        chk("idle_ovf_sat", int'(bs.overflow), int'(o_sat));
        chk("idle_sum_wrap", int'(bw.out_sum), m_wrp);
        chk("idle_ovf_wrap", int'(bw.overflow), int'(o_wrp));
      end
    end
    if (rst) begin
      q.delete();
      m_sat = 0; m_wrp = 0; o_sat = 0; o_wrp = 0;
      started = 1;
    end else if (started) begin
      if (exp_ov && out_ready) begin
        it.sat = int'(bs.out_sum); it.osat = bs.overflow;
        it.wrp = int'(bw.out_sum); it.owrp = bw.overflow;
        it.edge_no = cyc;
        log_q.push_back(it);
        void'(q.pop_front());
      end
      if (in_valid && exp_iv) begin
        apply(int'(in_op), int'(in_a) + int'(in_b), 1'b1, m_sat, o_sat);
        apply(int'(in_op), int'(in_a) + int'(in_b), 1'b0, m_wrp, o_wrp);
        it.sat = m_sat; it.osat = o_sat; it.wrp = m_wrp; it.owrp = o_wrp;
        it.edge_no = cyc + 1;
        q.push_back(it);
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input int a, input int b);
    int k = 0;
    in_op = op; in_a = W'(a); in_b = W'(b); in_valid = 1'b1;
    do begin @(negedge clk); k++; end while (!bs.in_ready && k < 100);
    if (k >= 100) begin errors++; $display("FAIL send_timeout: got in_ready 0 expected 1"); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while (q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) begin errors++; $display("FAIL drain_timeout: got %0d pending expected 0", q.size()); end
    @(posedge clk); #1;
  endtask

  initial begin
    int base, idx;
    int vals[4];
    vals = '{1, 2, 3, 4};

    // Reset / LOAD
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(bs.in_ready), 1);
    chk("rst_out_valid", int'(bs.out_valid), 0);
    chk("rst_out_sum", int'(bs.out_sum), 0);
    chk("rst_overflow", int'(bs.overflow), 0);
    @(posedge clk); #1;
    send(2'b00, 200, 100);
    @(negedge clk);
    chk("load_lat_edge1", int'(bs.out_valid), 0);
    @(negedge clk);
    chk("load_lat_edge2", int'(bs.out_valid), 1);
    chk("load_sum", int'(bs.out_sum), 300);
    chk("load_ovf", int'(bs.overflow), 0);
    @(posedge clk); #1;
    drain();

    // ACC saturate / wrap
    base = log_q.size();
    send(2'b11, 0, 0);
    for (int i = 0; i < 9; i++) send(2'b01, 255, 255);
    send(2'b11, 0, 0);
    drain();
    chk("acc_count", log_q.size() - base, 11);
    if (log_q.size() - base == 11) begin
      for (int i = 1; i <= 8; i++) begin
        chk("acc_sat_step", log_q[base+i].sat, 510 * i);
        chk("acc_wrap_step", log_q[base+i].wrp, 510 * i);
        chk("acc_step_ovf", int'(log_q[base+i].osat), 0);
      end
      chk("acc_sat_9", log_q[base+9].sat, 4095);
      chk("acc_sat_9_ovf", int'(log_q[base+9].osat), 1);
      chk("acc_wrap_9", log_q[base+9].wrp, 494);
      chk("acc_wrap_9_ovf", int'(log_q[base+9].owrp), 1);
      chk("clr_sum", log_q[base+10].sat, 0);
      chk("clr_ovf_sat", int'(log_q[base+10].osat), 0);
      chk("clr_ovf_wrap", int'(log_q[base+10].owrp), 0);
    end

    // SUB underflow
    base = log_q.size();
    send(2'b00, 200, 100);
    send(2'b10, 255, 255);
    drain();
    chk("sub_count", log_q.size() - base, 2);
    if (log_q.size() - base == 2) begin
      chk("sub_sat", log_q[base+1].sat, 0);
      chk("sub_wrap", log_q[base+1].wrp, 3886);
      chk("sub_sat_ovf", int'(log_q[base+1].osat), 1);
      chk("sub_wrap_ovf", int'(log_q[base+1].owrp), 1);
    end
    send(2'b11, 0, 0);
    drain();

    // Backpressure
    base = log_q.size();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_op = 2'b00; in_a = W'(vals[idx]); in_b = '0; in_valid = 1'b1;
      @(negedge clk);
      if (bs.in_ready) idx++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", idx, 2);
    in_a = W'(vals[idx]);
    @(negedge clk);
    chk("bp_in_ready", int'(bs.in_ready), 0);
    chk("bp_held_sum", int'(bs.out_sum), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = idx; i < 4; i++) send(2'b00, vals[i], 0);
    drain();
    chk("bp_count", log_q.size() - base, 4);
    if (log_q.size() - base == 4)
      for (int i = 0; i < 4; i++) chk("bp_order", log_q[base+i].sat, vals[i]);

    // Reset mid-stream
    out_ready = 1'b0;
    send(2'b00, 7, 0);
    send(2'b00, 8, 0);
    rst = 1'b1; in_valid = 1'b1; in_op = 2'b00; in_a = 8'd9; in_b = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", int'(bs.out_valid), 0);
    chk("mrst_out_sum", int'(bs.out_sum), 0);
    chk("mrst_in_ready", int'(bs.in_ready), 1);
    @(posedge clk); #1;
    base = log_q.size();
    send(2'b01, 5, 5);
    drain();
    chk("mrst_acc", (log_q.size() > base) ? log_q[base].sat : -1, 10);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 2'($urandom_range(0, 3));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
